// File: rtl/bdi_cache_pkg.sv
// Shared constants and types for the BDI data cache LRU age table.
package bdi_cache_pkg;

  localparam int NUM_SETS = 128;
  localparam int NUM_WAYS = 8;
  localparam int CNT_W    = 4;
  localparam int SET_W    = $clog2(NUM_SETS);
  localparam int WAY_W    = $clog2(NUM_WAYS);

  typedef logic [CNT_W-1:0] lru_cnt_t;
  typedef lru_cnt_t [NUM_WAYS-1:0] lru_set_t;

  localparam lru_cnt_t CNT_MAX  = {CNT_W{1'b1}};
  localparam lru_cnt_t CNT_ZERO = {CNT_W{1'b0}};
  localparam lru_cnt_t CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {OP_TOUCH = 1'b0, OP_INVAL = 1'b1} lru_op_e;
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} lru_state_e;

  // Age step for a way that was not touched: count down, stop at zero.
  function automatic lru_cnt_t sat_dec(input lru_cnt_t c);
    if (c == CNT_ZERO) begin
      return CNT_ZERO;
    end else begin
      return c - CNT_ONE;
    end
  endfunction

endpackage

// File: rtl/lru_age_update.sv
// Combinational next-state of the eight age counters of one set.
// TOUCH: addressed way -> CNT_MAX, every other way ages by one (saturating at 0).
// INVAL: addressed way -> 0, others untouched.
module lru_age_update
  import bdi_cache_pkg::*;
(
  input  lru_set_t          cnt_i,
  input  lru_op_e           op_i,
  input  logic [WAY_W-1:0]  way_i,
  output lru_set_t          cnt_o
);

  // Per-way update rule selected by the operation and the addressed way.
  always_comb begin
    cnt_o = cnt_i;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (way_i == WAY_W'(w)) begin
        if (op_i == OP_TOUCH) begin
          cnt_o[w] = CNT_MAX;
        end else begin
          cnt_o[w] = CNT_ZERO;
        end
      end else begin
        if (op_i == OP_TOUCH) begin
          cnt_o[w] = sat_dec(cnt_i[w]);
        end else begin
          cnt_o[w] = cnt_i[w];
        end
      end
    end
  end

endmodule

// File: rtl/lru_age_table.sv
// Per-set LRU age counter store for the 8-way, 128-set BDI data cache.
// After reset a 128-cycle sweep clears the (unreset) storage, then the table
// accepts one update and one lookup per cycle. Lookups respond one cycle later
// and see a same-cycle update to the same set (write-first).
// Optional feature macro: LRU_STATS_EN adds touch/inval update counters.
module lru_age_table
  import bdi_cache_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            upd_valid,
  output logic                            upd_ready,
  input  lru_op_e                         upd_op,
  input  logic [SET_W-1:0]                upd_set,
  input  logic [WAY_W-1:0]                upd_way,
  input  logic                            lkp_valid,
  output logic                            lkp_ready,
  input  logic [SET_W-1:0]                lkp_set,
  output logic                            resp_valid,
  output logic [NUM_WAYS-1:0][CNT_W-1:0]  resp_counter,
  output logic [SET_W-1:0]                resp_index7,
  output logic                            init_done
`ifdef LRU_STATS_EN
  ,
  output logic [31:0]                     stat_touch_cnt,
  output logic [31:0]                     stat_inval_cnt
`endif
);

  lru_state_e        state_q, state_d;
  logic [SET_W-1:0]  ptr_q, ptr_d;
  lru_set_t          mem_q [NUM_SETS];

  logic              run_s;
  logic              upd_fire_s;
  logic              lkp_fire_s;
  lru_set_t          upd_old_s;
  lru_set_t          upd_new_s;
  lru_set_t          lkp_data_s;

  logic              resp_valid_q;
  lru_set_t          resp_cnt_q;
  logic [SET_W-1:0]  resp_idx_q;

  assign run_s      = (state_q == ST_RUN);
  assign upd_fire_s = upd_valid && run_s;
  assign lkp_fire_s = lkp_valid && run_s;
  assign upd_old_s  = mem_q[upd_set];

  lru_age_update u_age_update (
    .cnt_i (upd_old_s),
    .op_i  (upd_op),
    .way_i (upd_way),
    .cnt_o (upd_new_s)
  );

  // Sweep sequencing: walk every set once, then stay in RUN until reset.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + SET_W'(1'b1);
        if (ptr_q == SET_W'(NUM_SETS - 1)) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // FSM state and sweep pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      ptr_q   <= {SET_W{1'b0}};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Counter storage: cleared by the sweep, then written by accepted updates.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[ptr_q] <= {NUM_WAYS{CNT_ZERO}};
    end else if (upd_fire_s) begin
      mem_q[upd_set] <= upd_new_s;
    end
  end

  // Lookup read data with same-set update bypass.
  always_comb begin
    if (upd_fire_s && (upd_set == lkp_set)) begin
      lkp_data_s = upd_new_s;
    end else begin
      lkp_data_s = mem_q[lkp_set];
    end
  end

  // Response register: one-cycle valid pulse, data holds between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_cnt_q   <= {NUM_WAYS{CNT_ZERO}};
      resp_idx_q   <= {SET_W{1'b0}};
    end else begin
      resp_valid_q <= lkp_fire_s;
      if (lkp_fire_s) begin
        resp_cnt_q <= lkp_data_s;
        resp_idx_q <= lkp_set;
      end
    end
  end

  assign upd_ready    = run_s;
  assign lkp_ready    = run_s;
  assign init_done    = run_s;
  assign resp_valid   = resp_valid_q;
  assign resp_counter = resp_cnt_q;
  assign resp_index7  = resp_idx_q;

`ifdef LRU_STATS_EN
  logic [31:0] touch_cnt_q;
  logic [31:0] inval_cnt_q;

  // Count accepted updates per operation type; wraps naturally at 2**32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      touch_cnt_q <= 32'd0;
      inval_cnt_q <= 32'd0;
    end else if (upd_fire_s) begin
      if (upd_op == OP_TOUCH) begin
        touch_cnt_q <= touch_cnt_q + 32'd1;
      end else begin
        inval_cnt_q <= inval_cnt_q + 32'd1;
      end
    end
  end

  assign stat_touch_cnt = touch_cnt_q;
  assign stat_inval_cnt = inval_cnt_q;
`endif

endmodule
